// File: rtl/nx_stream_dual_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// nx_stream_dual_arbiter_pkg
// Shared types for the node ingress stream arbiter: arbitration mode,
// forwarding direction, the mesh message layout and the bypass route decode.
// -----------------------------------------------------------------------------
package nx_stream_dual_arbiter_pkg;

   localparam int NX_ROW_W     = 4;
   localparam int NX_COL_W     = 4;
   localparam int NX_PAYLOAD_W = 24;

   typedef enum logic [0:0] {
      NX_ARB_RR    = 1'b0,
      NX_ARB_FIXED = 1'b1
   } nx_arb_mode_t;

   typedef enum logic [1:0] {
      NX_DIR_NORTH = 2'd0,
      NX_DIR_EAST  = 2'd1,
      NX_DIR_SOUTH = 2'd2,
      NX_DIR_WEST  = 2'd3
   } nx_direction_t;

   typedef struct packed {
      logic [NX_ROW_W-1:0] row;
      logic [NX_COL_W-1:0] column;
   } nx_header_t;

   typedef struct packed {
      nx_header_t              header;
      logic [NX_PAYLOAD_W-1:0] payload;
   } nx_raw_t;

   typedef struct packed {
      nx_raw_t raw;
   } nx_message_t;

   // Row distance is resolved before column distance (row-first routing).
   function automatic nx_direction_t nx_route_dir(
      input logic [NX_ROW_W-1:0] dst_row,
      input logic [NX_COL_W-1:0] dst_col,
      input logic [NX_ROW_W-1:0] node_row,
      input logic [NX_COL_W-1:0] node_col
   );
      nx_direction_t dir;
      if (dst_row > node_row) begin
         dir = NX_DIR_SOUTH;
      end else if (dst_row < node_row) begin
         dir = NX_DIR_NORTH;
      end else if (dst_col > node_col) begin
         dir = NX_DIR_EAST;
      end else begin
         dir = NX_DIR_WEST;
      end
      return dir;
   endfunction

endpackage

// File: rtl/nx_stream_dual_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// nx_rr_arbiter
// Round-robin / fixed-priority arbiter with a remembered last-grant pointer.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (pointer -> last index)
//   req_i        : request vector
//   enable_i     : grant allowed this cycle (output slot free)
//   mode_i       : NX_ARB_RR or NX_ARB_FIXED
//   grant_o      : one-hot grant (combinational), zero when nothing granted
// -----------------------------------------------------------------------------
module nx_rr_arbiter
   import nx_stream_dual_arbiter_pkg::*;
#(
   parameter int REQUESTORS = 4,
   localparam int PTR_W     = $clog2(REQUESTORS)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [REQUESTORS-1:0] req_i,
   input  logic                  enable_i,
   input  nx_arb_mode_t          mode_i,
   output logic [REQUESTORS-1:0] grant_o
);

   logic [PTR_W-1:0]      last_r;
   logic [REQUESTORS-1:0] grant_s;
   logic                  found_s;
   logic                  take_s;
   int                    best_idx_s;
   int                    best_dist_s;
   int                    dist_s;

   // Winner = requester with the smallest search distance. In RR the distance
   // counts from last_r+1 with wrap; in fixed mode it is the index itself.
   always_comb begin
      found_s     = 1'b0;
      take_s      = 1'b0;
      best_idx_s  = 0;
      best_dist_s = 0;
      dist_s      = 0;
      grant_s     = '0;
      for (int i = 0; i < REQUESTORS; i++) begin
         dist_s      = (mode_i == NX_ARB_FIXED) ? i
                     : ((i + REQUESTORS - 1 - int'(last_r)) % REQUESTORS);
         take_s      = enable_i && req_i[i] && (!found_s || (dist_s < best_dist_s));
         best_idx_s  = take_s ? i : best_idx_s;
         best_dist_s = take_s ? dist_s : best_dist_s;
         found_s     = found_s | take_s;
      end
      for (int i = 0; i < REQUESTORS; i++) begin
         grant_s[i] = found_s && (best_idx_s == i);
      end
   end

   assign grant_o = grant_s;

   // Last-grant pointer; updated on every grant in both modes so RR resumes fairly.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_r <= PTR_W'(REQUESTORS - 1);
      end else if (found_s) begin
         last_r <= PTR_W'(best_idx_s);
      end else begin
         last_r <= last_r;
      end
   end

endmodule

// File: rtl/nx_stream_dual_arbiter.sv
// -----------------------------------------------------------------------------
// nx_stream_dual_arbiter
// Routes STREAMS inbound messages to an internal slot (header matches this
// node) or a bypass slot (everything else). Each slot has its own arbiter so a
// stalled output never blocks the other.
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   node_row_i, node_col_i       : this node's mesh address (quasi-static)
//   mode_i                       : arbitration mode for both arbiters
//   in_data_i/in_valid_i/in_ready_o : inbound streams
//   internal_*                   : registered output for local messages
//   bypass_*                     : registered output for pass-through messages,
//                                  bypass_dir_o = forwarding direction
// -----------------------------------------------------------------------------
module nx_stream_dual_arbiter
   import nx_stream_dual_arbiter_pkg::*;
#(
   parameter int STREAMS        = 4,
   parameter int ADDR_ROW_WIDTH = NX_ROW_W,
   parameter int ADDR_COL_WIDTH = NX_COL_W
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [ADDR_ROW_WIDTH-1:0]       node_row_i,
   input  logic [ADDR_COL_WIDTH-1:0]       node_col_i,
   input  nx_arb_mode_t                    mode_i,
   input  nx_message_t [STREAMS-1:0]       in_data_i,
   input  logic [STREAMS-1:0]              in_valid_i,
   output logic [STREAMS-1:0]              in_ready_o,
   output nx_message_t                     internal_data_o,
   output logic                            internal_valid_o,
   input  logic                            internal_ready_i,
   output nx_message_t                     bypass_data_o,
   output nx_direction_t                   bypass_dir_o,
   output logic                            bypass_valid_o,
   input  logic                            bypass_ready_i
);

   localparam int MSG_W = $bits(nx_message_t);

   logic [STREAMS-1:0] match_s;
   logic [STREAMS-1:0] req_int_s;
   logic [STREAMS-1:0] req_byp_s;
   logic [STREAMS-1:0] grant_int_s;
   logic [STREAMS-1:0] grant_byp_s;
   logic               int_en_s;
   logic               byp_en_s;
   nx_message_t        int_sel_s;
   nx_message_t        byp_sel_s;

   logic               int_valid_r;
   nx_message_t        int_data_r;
   logic               byp_valid_r;
   nx_message_t        byp_data_r;
   nx_direction_t      byp_dir_r;

   // Address match splits each valid stream into exactly one request.
   always_comb begin
      match_s   = '0;
      req_int_s = '0;
      req_byp_s = '0;
      for (int i = 0; i < STREAMS; i++) begin
         match_s[i]   = (in_data_i[i].raw.header.row == node_row_i) &&
                        (in_data_i[i].raw.header.column == node_col_i);
         req_int_s[i] = in_valid_i[i] && match_s[i];
         req_byp_s[i] = in_valid_i[i] && !match_s[i];
      end
   end

   // A slot may reload in the same cycle it drains; reset blocks all grants.
   assign int_en_s = (!int_valid_r || internal_ready_i) && !rst_i;
   assign byp_en_s = (!byp_valid_r || bypass_ready_i) && !rst_i;

   nx_rr_arbiter #(.REQUESTORS(STREAMS)) u_arb_int (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    (req_int_s),
      .enable_i (int_en_s),
      .mode_i   (mode_i),
      .grant_o  (grant_int_s)
   );

   nx_rr_arbiter #(.REQUESTORS(STREAMS)) u_arb_byp (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    (req_byp_s),
      .enable_i (byp_en_s),
      .mode_i   (mode_i),
      .grant_o  (grant_byp_s)
   );

   assign in_ready_o = grant_int_s | grant_byp_s;

   // One-hot AND-OR mux of the granted message for each slot.
   always_comb begin
      int_sel_s = '0;
      byp_sel_s = '0;
      for (int i = 0; i < STREAMS; i++) begin
         int_sel_s = nx_message_t'(int_sel_s | (in_data_i[i] & {MSG_W{grant_int_s[i]}}));
         byp_sel_s = nx_message_t'(byp_sel_s | (in_data_i[i] & {MSG_W{grant_byp_s[i]}}));
      end
   end

   // Internal output slot: load on grant, clear valid on drain, data holds.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         int_valid_r <= 1'b0;
         int_data_r  <= '0;
      end else if (|grant_int_s) begin
         int_valid_r <= 1'b1;
         int_data_r  <= int_sel_s;
      end else if (internal_ready_i) begin
         int_valid_r <= 1'b0;
         int_data_r  <= int_data_r;
      end else begin
         int_valid_r <= int_valid_r;
         int_data_r  <= int_data_r;
      end
   end

   // Bypass output slot; direction is decoded at load time and held with data.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         byp_valid_r <= 1'b0;
         byp_data_r  <= '0;
         byp_dir_r   <= NX_DIR_NORTH;
      end else if (|grant_byp_s) begin
         byp_valid_r <= 1'b1;
         byp_data_r  <= byp_sel_s;
         byp_dir_r   <= nx_route_dir(byp_sel_s.raw.header.row, byp_sel_s.raw.header.column,
                                     node_row_i, node_col_i);
      end else if (bypass_ready_i) begin
         byp_valid_r <= 1'b0;
         byp_data_r  <= byp_data_r;
         byp_dir_r   <= byp_dir_r;
      end else begin
         byp_valid_r <= byp_valid_r;
         byp_data_r  <= byp_data_r;
         byp_dir_r   <= byp_dir_r;
      end
   end

   assign internal_valid_o = int_valid_r;
   assign internal_data_o  = int_data_r;
   assign bypass_valid_o   = byp_valid_r;
   assign bypass_data_o    = byp_data_r;
   assign bypass_dir_o     = byp_dir_r;

endmodule
